// File: rtl/fdiv_sqrt_pkg.sv
// ==========================================================================
// fdiv_sqrt_pkg : shared types and defaults for the fdiv/fsqrt sequencer
// Revision 1.0  : initial release
// ==========================================================================
`default_nettype none

package fdiv_sqrt_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_NORM = 3'd3,
      S_WB   = 3'd4
   } state_t;

   localparam int DIV_ITERS_DEF  = 24;
   localparam int SQRT_ITERS_DEF = 26;

   typedef logic [4:0] iter_cnt_t;

endpackage : fdiv_sqrt_pkg

`default_nettype wire

// File: rtl/fds_iter_cnt.sv
// ==========================================================================
// fds_iter_cnt : loadable 5-bit down-counter with zero flag
// Revision 1.0 : initial release
// ==========================================================================
`default_nettype none

module fds_iter_cnt
   import fdiv_sqrt_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  iter_cnt_t load_val,
   input  logic      dec,
   output iter_cnt_t cnt,
   output logic      zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 5'd1;
      end
   end

   assign zero = (cnt == '0);

endmodule : fds_iter_cnt

`default_nettype wire

// File: rtl/fdiv_sqrt_ctrl.sv
// ==========================================================================
// fdiv_sqrt_ctrl : sequencer for the iterative fdiv/fsqrt datapath
// Build option   : FDIV_SQRT_FSQRT_EN enables fsqrt (otherwise rejected)
// Revision 1.0   : initial release
// ==========================================================================
`default_nettype none

module fdiv_sqrt_ctrl
   import fdiv_sqrt_pkg::*;
#(
   parameter int DIV_ITERS  = DIV_ITERS_DEF,
   parameter int SQRT_ITERS = SQRT_ITERS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       is_sqrt,
   input  logic [4:0] dst,
   input  logic       flush,
   input  logic       wb_gnt,
   output logic       ld,
   output logic       step_en,
   output logic       norm,
   output logic       op_sqrt,
   output logic [4:0] iter_cnt,
   output logic       wb_req,
   output logic [4:0] wb_dst,
   output logic       busy,
   output logic       stall_div_sqrt,
   output logic       unimpl
);

   state_t    state;
   logic      accept;
   logic      reject;
   logic      cnt_load;
   logic      cnt_dec;
   logic      cnt_zero;
   iter_cnt_t load_val;

`ifdef FDIV_SQRT_FSQRT_EN
   assign accept = start & ~flush;
   assign reject = 1'b0;
`else
   assign accept = start & ~flush & ~is_sqrt;
   assign reject = start & ~flush &  is_sqrt;
`endif

   // op_sqrt can only be set when fsqrt is built in, so SQRT_ITERS is
   // effectively dead in the fdiv-only build
   assign load_val = op_sqrt ? iter_cnt_t'(SQRT_ITERS - 1) : iter_cnt_t'(DIV_ITERS - 1);
   assign cnt_load = (state == S_LOAD) & ~flush;
   assign cnt_dec  = (state == S_ITER) & ~flush;

   fds_iter_cnt u_iter_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (load_val),
      .dec      (cnt_dec),
      .cnt      (iter_cnt),
      .zero     (cnt_zero)
   );

   assign stall_div_sqrt = start & (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ld      <= 1'b0;
         step_en <= 1'b0;
         norm    <= 1'b0;
         wb_req  <= 1'b0;
         busy    <= 1'b0;
         unimpl  <= 1'b0;
         op_sqrt <= 1'b0;
         wb_dst  <= '0;
      end else begin
         ld      <= 1'b0;
         step_en <= 1'b0;
         norm    <= 1'b0;
         wb_req  <= 1'b0;
         unimpl  <= 1'b0;
         busy    <= 1'b1;
         if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     state   <= S_LOAD;
                     ld      <= 1'b1;
                     op_sqrt <= is_sqrt;
                     wb_dst  <= dst;
                  end else begin
                     busy   <= 1'b0;
                     unimpl <= reject;
                  end
               end
               S_LOAD: begin
                  state   <= S_ITER;
                  step_en <= 1'b1;
               end
               // counter reaches zero on the last of the N step cycles
               S_ITER: begin
                  if (cnt_zero) begin
                     state <= S_NORM;
                     norm  <= 1'b1;
                  end else begin
                     step_en <= 1'b1;
                  end
               end
               S_NORM: begin
                  state  <= S_WB;
                  wb_req <= 1'b1;
               end
               S_WB: begin
                  if (wb_gnt) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     wb_req <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : fdiv_sqrt_ctrl

`default_nettype wire

// File: tb/tb_fdiv_sqrt_ctrl.sv
// ==========================================================================
// tb_fdiv_sqrt_ctrl : self-checking bench for fdiv_sqrt_ctrl
// Revision 1.0      : initial release
// ==========================================================================
`default_nettype none

module tb_fdiv_sqrt_ctrl;

   localparam int NDIV  = 24;
   localparam int NSQRT = 26;
`ifdef FDIV_SQRT_FSQRT_EN
   localparam bit SQRT_EN = 1'b1;
`else
   localparam bit SQRT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       is_sqrt = 1'b0;
   logic [4:0] dst = 5'd0;
   logic       flush = 1'b0;
   logic       wb_gnt = 1'b0;
   logic       ld, step_en, norm, op_sqrt, wb_req, busy, stall_div_sqrt, unimpl;
   logic [4:0] iter_cnt, wb_dst;

   fdiv_sqrt_ctrl #(.DIV_ITERS(NDIV), .SQRT_ITERS(NSQRT)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .is_sqrt        (is_sqrt),
      .dst            (dst),
      .flush          (flush),
      .wb_gnt         (wb_gnt),
      .ld             (ld),
      .step_en        (step_en),
      .norm           (norm),
      .op_sqrt        (op_sqrt),
      .iter_cnt       (iter_cnt),
      .wb_req         (wb_req),
      .wb_dst         (wb_dst),
      .busy           (busy),
      .stall_div_sqrt (stall_div_sqrt),
      .unimpl         (unimpl)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted job is tracked by its age in cycles since acceptance
   bit         m_active = 1'b0;
   int         m_age = 0;
   int         m_n = 0;
   int         m_cnt = 0;
   bit         m_sqrt = 1'b0;
   bit         m_unimpl = 1'b0;
   logic [4:0] m_dst = 5'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (m_active && m_age >= 2)
            m_cnt = (m_age <= m_n + 1) ? (m_n + 1 - m_age) : 0;
         chk("m_busy",    busy,    m_active);
         chk("m_ld",      ld,      m_active && m_age == 1);
         chk("m_step_en", step_en, m_active && m_age >= 2 && m_age <= m_n + 1);
         chk("m_norm",    norm,    m_active && m_age == m_n + 2);
         chk("m_wb_req",  wb_req,  m_active && m_age >= m_n + 3);
         chk("m_iter_cnt", iter_cnt, m_cnt);
         chk("m_wb_dst",  wb_dst,  m_dst);
         chk("m_op_sqrt", op_sqrt, m_sqrt);
         chk("m_stall",   stall_div_sqrt, start && m_active);
         chk("m_unimpl",  unimpl,  m_unimpl);
         if (rst) begin
            m_active = 1'b0; m_cnt = 0; m_sqrt = 1'b0; m_dst = 5'd0; m_unimpl = 1'b0;
         end else begin
            m_unimpl = 1'b0;
            if (flush) begin
               m_active = 1'b0;
            end else if (m_active) begin
               if (m_age >= m_n + 3 && wb_gnt) m_active = 1'b0;
               else m_age++;
            end else if (start) begin
               if (is_sqrt && !SQRT_EN) begin
                  m_unimpl = 1'b1;
               end else begin
                  m_active = 1'b1; m_age = 1;
                  m_n = is_sqrt ? NSQRT : NDIV;
                  m_sqrt = is_sqrt; m_dst = dst;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_wbreq(input int lim);
      int k;
      k = 0;
      #1;
      while (!wb_req && k < lim) begin
         tick();
         #1;
         k++;
      end
      chk("wb_req_wait", wb_req, 1);
   endtask

   initial begin
      int c;
      // reset state
      repeat (3) tick();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_iter_cnt", iter_cnt, 0);
      chk("rst_wb_dst", wb_dst, 0);
      chk("rst_op_sqrt", op_sqrt, 0);
      chk("rst_unimpl", unimpl, 0);
      chk("rst_wb_req", wb_req, 0);
      rst = 1'b0;

      // fdiv dst=7: ld T+1, 24 steps, norm T+26, wb_req T+27
      tick(); start = 1'b1; is_sqrt = 1'b0; dst = 5'd7;
      tick(); start = 1'b0;
      #1;
      chk("fdiv_ld_T1", ld, 1);
      c = 0;
      for (int i = 0; i < NDIV; i++) begin
         tick(); #1;
         if (step_en) c++;
         if (i == 0) chk("fdiv_iter_first", iter_cnt, 23);
      end
      chk("fdiv_step_count", c, 24);
      tick(); #1;
      chk("fdiv_norm_T26", norm, 1);
      tick(); #1;
      chk("fdiv_wb_req_T27", wb_req, 1);
      chk("fdiv_wb_dst", wb_dst, 7);
      wb_gnt = 1'b1;
      tick(); wb_gnt = 1'b0;
      #1;
      chk("fdiv_idle_after_gnt", busy, 0);

      // grant withheld 5 WB cycles, new start in the grant cycle
      start = 1'b1; is_sqrt = SQRT_EN; dst = 5'd3;
      tick(); start = 1'b0; is_sqrt = 1'b0;
      wait_wbreq(40);
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("wb_req_hold", wb_req, 1);
         chk("busy_hold", busy, 1);
      end
      wb_gnt = 1'b1; start = 1'b1; dst = 5'd9;
      #1;
      chk("stall_in_gnt", stall_div_sqrt, 1);
      tick(); wb_gnt = 1'b0;
      #1;
      chk("idle_after_gnt", busy, 0);
      tick(); start = 1'b0;
      #1;
      chk("accept_after_gnt_ld", ld, 1);
      chk("accept_after_gnt_dst", wb_dst, 9);

      // second start during ITER is stalled
      repeat (3) tick();
      start = 1'b1; dst = 5'd20;
      #1;
      chk("stall_in_iter", stall_div_sqrt, 1);
      tick(); start = 1'b0;
      #1;
      chk("dst_kept_after_stall", wb_dst, 9);
      wait_wbreq(40);
      chk("dst_kept_at_wb", wb_dst, 9);
      wb_gnt = 1'b1;
      tick(); wb_gnt = 1'b0;

      // flush at the 10th ITER cycle, then immediate restart
      start = 1'b1; dst = 5'd11;
      tick(); start = 1'b0;
      repeat (10) tick();
      #1;
      chk("iter10_step_en", step_en, 1);
      chk("iter10_cnt", iter_cnt, 14);
      flush = 1'b1;
      tick(); flush = 1'b0;
      #1;
      chk("flush_busy", busy, 0);
      chk("flush_step_en", step_en, 0);
      start = 1'b1; dst = 5'd12;
      tick(); start = 1'b0;
      #1;
      chk("restart_ld", ld, 1);
      chk("restart_dst", wb_dst, 12);

      // reset during WB
      wait_wbreq(40);
      rst = 1'b1;
      tick(); rst = 1'b0;
      #1;
      chk("rstwb_wb_req", wb_req, 0);
      chk("rstwb_busy", busy, 0);
      chk("rstwb_dst", wb_dst, 0);
      chk("rstwb_iter_cnt", iter_cnt, 0);

      // flush beats start
      start = 1'b1; flush = 1'b1; dst = 5'd4;
      tick(); start = 1'b0; flush = 1'b0;
      #1;
      chk("flush_beats_start", busy, 0);

      // fsqrt request: rejected unless built in
      start = 1'b1; is_sqrt = 1'b1; dst = 5'd15;
      tick(); start = 1'b0; is_sqrt = 1'b0;
      #1;
`ifdef FDIV_SQRT_FSQRT_EN
      chk("fsqrt_unimpl", unimpl, 0);
      chk("fsqrt_busy", busy, 1);
      wait_wbreq(60);
      chk("fsqrt_op", op_sqrt, 1);
      wb_gnt = 1'b1;
      tick(); wb_gnt = 1'b0;
`else
      chk("fsqrt_unimpl", unimpl, 1);
      chk("fsqrt_busy", busy, 0);
      tick(); #1;
      chk("fsqrt_unimpl_pulse", unimpl, 0);
`endif
      start = 1'b1; dst = 5'd5;
      tick(); start = 1'b0;
      wait_wbreq(40);
      chk("post_fdiv_dst", wb_dst, 5);
      chk("post_fdiv_op", op_sqrt, 0);
      wb_gnt = 1'b1;
      tick(); wb_gnt = 1'b0;
      #1;
      chk("post_fdiv_idle", busy, 0);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fdiv_sqrt_ctrl

`default_nettype wire
